keccak_stream_padder: RTL

- Streaming, parametrised successor to the single-word SHAKE padder.
- Accepts message words over a valid/ready handshake and emits rate-aligned, fully padded words. Supports run-time domain separator selection: SHA3, SHAKE or raw Keccak.
- Tracks the word position within the rate block itself. When padding does not fit in the current block, it generates whole padding words and an extra block.
- Sits between the message input FIFO and the Keccak absorb/state-XOR stage.

---
 rtl/keccak_stream_padder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/keccak_stream_padder.sv
// Streaming Keccak padder: passes message words through and appends DS/0x80 padding up to a rate-block boundary.
// Optional message/block counters are enabled by defining KECCAK_STREAM_PADDER_LEN_CNT_EN.
module keccak_stream_padder #(
  parameter int W          = 64,
  parameter int RATE_WORDS = 21,
  parameter int BW         = $clog2(W/8) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  input  logic [BW-1:0] in_bytes,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_last_in_block,
  output logic          out_last,
  output logic          busy
`ifdef KECCAK_STREAM_PADDER_LEN_CNT_EN
  , output logic [63:0] msg_len_bytes,
  output logic [15:0]   blk_cnt
`endif
);

  localparam int NB = W / 8;
  localparam int CW = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam logic [BW-1:0] NB_B     = BW'(NB);
  localparam logic [CW-1:0] LAST_CNT = CW'(RATE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ABSORB, PAD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    ds_q, ds_d;
  logic          pend_q, pend_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          out_lib_q, out_lib_d;

  logic          load, accept, blk_end, emit, word_last;
  logic [BW-1:0] nbytes;
  logic [W-1:0]  tail_word, pad_word, word;

  assign load     = !out_valid_q | out_ready;
  assign in_ready = (state_q == ABSORB) & load;
  assign accept   = in_valid & in_ready;
  assign blk_end  = (cnt_q == LAST_CNT);
  assign nbytes   = (in_bytes > NB_B) ? NB_B : in_bytes;
  assign pad_word = {(pend_q ? ds_q : 8'h00), {(W-8){1'b0}}};

  // Final partial word: keep the leading message bytes, put DS right after them, zero the rest.
  for (genvar gi = 0; gi < NB; gi++) begin : g_byte
    assign tail_word[W-1-8*gi -: 8] = (BW'(gi) < nbytes)  ? in_data[W-1-8*gi -: 8] :
                                      (BW'(gi) == nbytes) ? ds_q : 8'h00;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ds_d        = ds_q;
    pend_d      = pend_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_lib_d   = out_lib_q;
    emit        = 1'b0;
    word        = '0;
    word_last   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ABSORB;
          cnt_d   = '0;
          case (mode)
            2'b00:   ds_d = 8'h06;
            2'b10:   ds_d = 8'h01;
            default: ds_d = 8'h1F;
          endcase
        end
      end
      ABSORB: begin
        if (accept) begin
          emit = 1'b1;
          if (!in_last) begin
            word = in_data;
          end else if (nbytes == NB_B) begin
            word    = in_data;
            pend_d  = 1'b1;
            state_d = PAD;
          end else begin
            word   = tail_word;
            pend_d = 1'b0;
            if (blk_end) begin
              word_last = 1'b1;
              state_d   = IDLE;
            end else begin
              state_d = PAD;
            end
          end
        end
      end
      PAD: begin
        if (load) begin
          emit   = 1'b1;
          word   = pad_word;
          pend_d = 1'b0;
          if (blk_end) begin
            word_last = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (word_last) word[7:0] = word[7:0] | 8'h80;
    if (load) begin
      out_valid_d = emit;
      out_last_d  = word_last;
      out_lib_d   = emit & blk_end;
      if (emit) out_data_d = word;
    end
    if (emit) cnt_d = blk_end ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ds_q        <= '0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_lib_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ds_q        <= ds_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_lib_q   <= out_lib_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_last          = out_last_q;
  assign out_last_in_block = out_lib_q;
  assign busy              = (state_q != IDLE) | out_valid_q;

`ifdef KECCAK_STREAM_PADDER_LEN_CNT_EN
  logic [63:0] len_q;
  logic [15:0] blk_q;

  always_ff @(posedge clk) begin
    if (rst || (state_q == IDLE && start)) begin
      len_q <= '0;
      blk_q <= '0;
    end else begin
      if (accept) len_q <= len_q + (in_last ? 64'(nbytes) : 64'(NB));
      if (emit && blk_end) blk_q <= blk_q + 16'd1;
    end
  end

  assign msg_len_bytes = len_q;
  assign blk_cnt       = blk_q;
`endif

endmodule
